osc_neuron_bank: RTL

OSC_NEURON_BANK -- requirements
Module: osc_neuron_bank

---
 rtl/osc_pkg.sv | 15 +
 rtl/osc_cell.sv | 93 +++++++++
 rtl/osc_neuron_bank.sv | 60 ++++++
 3 files changed

// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared types and default parameters for the oscillator neuron bank
package osc_pkg;

  // Channel activity: counting towards threshold, or holding after a spike
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_REFR = 1'b1
  } osc_state_t;

  localparam int OSC_N_CH = 4;
  localparam int OSC_CW   = 8;
  localparam int OSC_RW   = 4;
  localparam int OSC_KICK = 2;

endpackage

// File: rtl/osc_cell.sv
// rtl/osc_cell.sv - one integrate-and-fire oscillator channel with refractory hold
module osc_cell
  import osc_pkg::*;
#(
  parameter int CW   = OSC_CW,
  parameter int RW   = OSC_RW,
  parameter int KICK = OSC_KICK
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [CW-1:0] i_threshold,
  input  logic [RW-1:0] i_refrac,
  input  logic          i_kick,
  output logic          o_spike,
  output logic          o_spike_nxt,
  output logic [CW-1:0] o_count
);

  // One extra bit so count + 1 + KICK can never wrap before the clamp
  localparam logic [CW:0] ONE_W  = (CW+1)'(1);
  localparam logic [CW:0] KICK_W = (CW+1)'(KICK);

  osc_state_t    r_state;
  logic [CW-1:0] r_count;
  logic [RW-1:0] r_rcnt;
  logic          r_spike;

  osc_state_t    w_state_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [RW-1:0] w_rcnt_nxt;
  logic          w_spike_nxt;
  logic [CW:0]   w_sum;

  // Next-state logic: fire at or above threshold, otherwise integrate with saturation
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_rcnt_nxt  = r_rcnt;
    w_spike_nxt = 1'b0;
    w_sum       = {1'b0, r_count} + ONE_W + (i_kick ? KICK_W : '0);
    if (i_en) begin
      case (r_state)
        ST_RUN: begin
          if (r_count >= i_threshold) begin
            w_spike_nxt = 1'b1;
            w_count_nxt = '0;
            // refrac is sampled only here, so changes wait for the next spike
            if (i_refrac != '0) begin
              w_state_nxt = ST_REFR;
              w_rcnt_nxt  = i_refrac;
            end
          end else if (w_sum >= {1'b0, i_threshold}) begin
            w_count_nxt = i_threshold;
          end else begin
            w_count_nxt = w_sum[CW-1:0];
          end
        end
        ST_REFR: begin
          // Kicks are deliberately ignored while refractory
          w_count_nxt = '0;
          w_rcnt_nxt  = r_rcnt - RW'(1);
          if (r_rcnt == RW'(1)) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // State register with asynchronous clear so a reset abandons any spike or hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
      r_count <= '0;
      r_rcnt  <= '0;
      r_spike <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_spike <= w_spike_nxt;
    end
  end

  assign o_spike     = r_spike;
  assign o_spike_nxt = w_spike_nxt;
  assign o_count     = r_count;

endmodule

// File: rtl/osc_neuron_bank.sv
// rtl/osc_neuron_bank.sv - ring of oscillator channels with nearest-neighbour coupling and sync detect
module osc_neuron_bank
  import osc_pkg::*;
#(
  parameter int N_CH = OSC_N_CH,
  parameter int CW   = OSC_CW,
  parameter int RW   = OSC_RW,
  parameter int KICK = OSC_KICK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CW-1:0]    threshold,
  input  logic [RW-1:0]    refrac,
  input  logic             couple_en,
  input  logic [N_CH-1:0]  ext_kick,
  output logic [N_CH-1:0]  spike,
  output logic [N_CH*CW-1:0] phase,
  output logic             sync
);

  logic [N_CH-1:0] w_kick;
  logic [N_CH-1:0] w_spike_nxt;
  logic            r_sync;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Upstream neighbour in the ring; with one channel it is the channel itself
    localparam int PREV = (i + N_CH - 1) % N_CH;

    assign w_kick[i] = ext_kick[i] | (couple_en & spike[PREV]);

    osc_cell #(
      .CW   (CW),
      .RW   (RW),
      .KICK (KICK)
    ) u_cell (
      .i_clk       (clk),
      .i_rst_n     (reset),
      .i_en        (en),
      .i_threshold (threshold),
      .i_refrac    (refrac),
      .i_kick      (w_kick[i]),
      .o_spike     (spike[i]),
      .o_spike_nxt (w_spike_nxt[i]),
      .o_count     (phase[i*CW +: CW])
    );
  end

  // Sync is registered from the same next-spike terms so it lines up with spike
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= 1'b0;
    end else begin
      r_sync <= &w_spike_nxt;
    end
  end

  assign sync = r_sync;

endmodule
